// File: rtl/calc_result_serializer_if.sv
// -----------------------------------------------------------------------------
// calc_result_serializer_if
// Purpose : groups the triple-input handshake and the byte-output handshake of
//           calc_result_serializer into one bundle.
// Signals :
//   in_valid  producer -> serializer  triple offered
//   in_ready  serializer -> producer  triple accepted when in_valid && in_ready
//   in_a/b/c  producer -> serializer  calculator results out1/out2/out3
//   out_valid serializer -> consumer  byte offered
//   out_ready consumer -> serializer  byte taken when out_valid && out_ready
//   out_data  serializer -> consumer  current byte
//   out_tag   serializer -> consumer  0 = a, 1 = b, 2 = c
//   out_last  serializer -> consumer  high with the c byte
// Modports: master = producer/consumer side (testbench, calculator, bus),
//           slave  = serializer side.
// -----------------------------------------------------------------------------
interface calc_result_serializer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_tag;
    logic             out_last;

    modport master (
        output in_valid,
        input  in_ready,
        output in_a,
        output in_b,
        output in_c,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_tag,
        input  out_last
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  in_a,
        input  in_b,
        input  in_c,
        output out_valid,
        input  out_ready,
        output out_data,
        output out_tag,
        output out_last
    );
endinterface

// File: rtl/calc_result_serializer.sv
// -----------------------------------------------------------------------------
// calc_result_serializer
// Purpose : accepts the calculator's three results per sample as one triple,
//           buffers triples in a DEPTH-entry circular FIFO and serialises each
//           triple as a/b/c bytes on a valid/ready byte stream. Optionally keeps
//           a running checksum of every emitted byte.
// Ports   :
//   clk    rising-edge clock
//   rst    synchronous active-high reset, overrides everything
//   bus    calc_result_serializer_if.slave (triple in, byte out)
//   count  triples stored, 0..DEPTH
//   acc    running checksum of emitted bytes (wraps modulo 2^ACC_W)
// Config  : define CALC_RESULT_SERIALIZER_ACC_EN to build the checksum
//           register; otherwise acc is tied to 0. Port list is identical.
// -----------------------------------------------------------------------------
module calc_result_serializer #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned ACC_W = WIDTH + 8
) (
    input  logic                       clk,
    input  logic                       rst,
    calc_result_serializer_if.slave    bus,
    output logic [AW:0]                count,
    output logic [ACC_W-1:0]           acc
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] TWO_CNT  = (AW+1)'(2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SA   = 2'd1,
        SB   = 2'd2,
        SC   = 2'd3
    } state_t;

    // FIFO storage, one array per result lane
    logic [WIDTH-1:0] r_mem_a [DEPTH];
    logic [WIDTH-1:0] r_mem_b [DEPTH];
    logic [WIDTH-1:0] r_mem_c [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    state_t           r_state;
    state_t           w_state_nxt;

    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_out_hs;
    logic             w_out_valid;
    logic [WIDTH-1:0] w_out_data;
    logic [1:0]       w_out_tag;
    logic             w_out_last;

    // No bypass: a full FIFO refuses input even if the head pops this cycle
    assign w_in_ready = (r_count != FULL_CNT) && !rst;
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_out_hs   = w_out_valid && bus.out_ready;
    // Head leaves the FIFO only once its c byte is taken
    assign w_pop      = w_out_hs && (r_state == SC);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and byte-output decode; head is read in place
    always_comb begin
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        w_out_data  = '0;
        w_out_tag   = 2'd0;
        w_out_last  = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_count != '0) begin
                    w_state_nxt = SA;
                end
            end
            SA: begin
                w_out_valid = 1'b1;
                w_out_data  = r_mem_a[r_rd_ptr];
                w_out_tag   = 2'd0;
                if (bus.out_ready) begin
                    w_state_nxt = SB;
                end
            end
            SB: begin
                w_out_valid = 1'b1;
                w_out_data  = r_mem_b[r_rd_ptr];
                w_out_tag   = 2'd1;
                if (bus.out_ready) begin
                    w_state_nxt = SC;
                end
            end
            SC: begin
                w_out_valid = 1'b1;
                w_out_data  = r_mem_c[r_rd_ptr];
                w_out_tag   = 2'd2;
                w_out_last  = 1'b1;
                // Pre-pop count decides whether another triple follows directly
                if (bus.out_ready) begin
                    w_state_nxt = (r_count >= TWO_CNT) ? SA : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Reset blanks the byte stream in the very cycle it is asserted
        if (rst) begin
            w_out_valid = 1'b0;
            w_out_data  = '0;
            w_out_tag   = 2'd0;
            w_out_last  = 1'b0;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage write; contents need no reset, pointers define validity
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= bus.in_a;
            r_mem_b[r_wr_ptr] <= bus.in_b;
            r_mem_c[r_wr_ptr] <= bus.in_c;
        end
    end

`ifdef CALC_RESULT_SERIALIZER_ACC_EN
    logic [ACC_W-1:0] r_acc;

    // Running checksum of every taken byte, wraps silently
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_out_hs) begin
            r_acc <= r_acc + ACC_W'(w_out_data);
        end
    end

    assign acc = r_acc;
`else
    assign acc = '0;
`endif

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.out_tag   = w_out_tag;
    assign bus.out_last  = w_out_last;
    assign count         = r_count;

endmodule
